// File: rtl/regfile_write_bank.sv
// regfile_write_bank: write side of the integer register file.
// Holds the architectural register storage, decodes the writeback port into
// per-register enables, exposes every register in parallel for the read
// muxes, and keeps a per-register busy scoreboard for the hazard unit.
// The hardwired-zero register has no storage at all: it reads as zero, never
// becomes busy, and writes to it are dropped without being counted.
module regfile_write_bank #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  logic [4:0]       writeRegister,
  input  logic [WIDTH-1:0] writeData,
  input  logic             setBusy,
  input  logic [4:0]       busyRegister,
  output logic [WIDTH-1:0] dataFromReg [NREGS-1:0],
  output logic [NREGS-1:0] busy,
  output logic [15:0]      writeCount
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  // A write only commits when it targets a real register.
  logic commit;
  assign commit = RegWrite && (writeRegister != ZERO_IDX);

  logic [15:0] write_count_d;
  logic [15:0] write_count_q;

  // Committed-write counter, wraps silently at 16 bits.
  always_comb begin
    write_count_d = write_count_q;
    if (commit) begin
      write_count_d = write_count_q + 16'd1;
    end
  end

  // Counter state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  assign writeCount = write_count_q;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [4:0] IDX = 5'(gi);

      if (gi == ZERO_REG) begin : g_zero
        // No storage: constant zero and never busy.
        assign dataFromReg[gi] = '0;
        assign busy[gi]        = 1'b0;
      end else begin : g_live
        logic             wr_en;
        logic             set_busy;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_q;
        logic             busy_d;
        logic             busy_q;

        // One-hot write enable and scoreboard update; a new reservation
        // beats a writeback landing in the same cycle.
        always_comb begin
          wr_en    = RegWrite && (writeRegister == IDX);
          set_busy = setBusy && (busyRegister == IDX);
          data_d   = data_q;
          busy_d   = busy_q;
          if (wr_en) begin
            data_d = writeData;
            busy_d = 1'b0;
          end
          if (set_busy) begin
            busy_d = 1'b1;
          end
        end

        // Register storage and busy flag, cleared asynchronously.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
          end else begin
            data_q <= data_d;
            busy_q <= busy_d;
          end
        end

        assign dataFromReg[gi] = data_q;
        assign busy[gi]        = busy_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: table-driven scoreboard
// vectors, hand-written reset/readback/zero-register sequences, randomized
// traffic against a reference model, and a counter wrap run.
module tb_regfile_write_bank;

  logic        clk;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;
  logic        setBusy;
  logic [4:0]  busyRegister;
  logic [63:0] dataFromReg [31:0];
  logic [31:0] busy;
  logic [15:0] writeCount;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays updated by the architectural rules.
  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  int          m_count;

  regfile_write_bank #(.WIDTH(64), .NREGS(32), .ZERO_REG(31)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RegWrite     (RegWrite),
    .writeRegister(writeRegister),
    .writeData    (writeData),
    .setBusy      (setBusy),
    .busyRegister (busyRegister),
    .dataFromReg  (dataFromReg),
    .busy         (busy),
    .writeCount   (writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        sb;
    logic [4:0]  br;
    logic [4:0]  chk_idx;
    logic [63:0] exp_data;
    logic [31:0] exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [7];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy  = '0;
    m_count = 0;
  endtask

  // Architectural effect of one rising edge with the current inputs.
  task automatic model_edge();
    if (RegWrite && writeRegister != 5'd31) begin
      m_regs[writeRegister] = writeData;
      m_busy[writeRegister] = 1'b0;
      m_count = (m_count + 1) % 65536;
    end
    if (setBusy && busyRegister != 5'd31) begin
      m_busy[busyRegister] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_state(input string name);
    for (int i = 0; i < 32; i++) begin
      cmp($sformatf("%s reg[%0d]", name, i), dataFromReg[i], m_regs[i]);
    end
    cmp({name, " busy"}, {32'd0, busy}, {32'd0, m_busy});
    cmp({name, " writeCount"}, {48'd0, writeCount}, 64'(m_count));
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                       input logic sb, input logic [4:0] br);
    RegWrite      = we;
    writeRegister = wr;
    writeData     = wd;
    setBusy       = sb;
    busyRegister  = br;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    #1;
    check_state("reset");
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    model_clear();
    #1;
    check_state("por");
    cmp("por busy zero", {32'd0, busy}, 64'd0);
    cmp("por count zero", {48'd0, writeCount}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Scoreboard vectors, expectations written by hand.
    vecs[0] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd7,  5'd7,  64'h0,    32'h0000_0080, 16'd0};
    vecs[1] = '{1'b1, 5'd7,  64'h55,               1'b0, 5'd0,  5'd7,  64'h55,   32'h0000_0000, 16'd1};
    vecs[2] = '{1'b1, 5'd7,  64'h1234,             1'b1, 5'd7,  5'd7,  64'h1234, 32'h0000_0080, 16'd2};
    vecs[3] = '{1'b1, 5'd7,  64'h77,               1'b0, 5'd0,  5'd7,  64'h77,   32'h0000_0000, 16'd3};
    vecs[4] = '{1'b1, 5'd9,  64'h99,               1'b1, 5'd3,  5'd9,  64'h99,   32'h0000_0008, 16'd4};
    vecs[5] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 5'd31, 64'h0, 32'h0000_0008, 16'd4};
    vecs[6] = '{1'b1, 5'd3,  64'h33,               1'b0, 5'd0,  5'd3,  64'h33,   32'h0000_0000, 16'd5};

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].sb, vecs[v].br);
      tick();
      cmp($sformatf("vec%0d data", v), dataFromReg[vecs[v].chk_idx], vecs[v].exp_data);
      cmp($sformatf("vec%0d busy", v), {32'd0, busy}, {32'd0, vecs[v].exp_busy});
      cmp($sformatf("vec%0d count", v), {48'd0, writeCount}, {48'd0, vecs[v].exp_count});
      check_state($sformatf("vec%0d model", v));
      $display("vec %0d we=%0d wr=%0d sb=%0d br=%0d busy=%h count=%0d",
               v, vecs[v].we, vecs[v].wr, vecs[v].sb, vecs[v].br, busy, writeCount);
    end
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);

    // Write/readback of every real register from a clean reset.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 5'd0);
      tick();
      cmp($sformatf("readback x%0d", i), dataFromReg[i], 64'hA5A5_0000_0000_0000 + 64'(i));
      check_state($sformatf("readback x%0d", i));
      $display("write x%0d data=%h count=%0d", i, dataFromReg[i], writeCount);
    end
    cmp("readback count", {48'd0, writeCount}, 64'd31);

    // Zero register: write and reservation both ignored.
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31);
    tick();
    cmp("xzr data", dataFromReg[31], 64'h0);
    cmp("xzr busy", {63'd0, busy[31]}, 64'd0);
    cmp("xzr count", {48'd0, writeCount}, 64'd31);
    $display("xzr write data=%h busy31=%0d count=%0d", dataFromReg[31], busy[31], writeCount);

    // Asynchronous reset mid-cycle with a write pending; the write is lost.
    drive(1'b1, 5'd2, 64'hDEAD_BEEF_0000_0002, 1'b1, 5'd5);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    cmp("async reset x0", dataFromReg[0], 64'h0);
    cmp("async reset x5", dataFromReg[5], 64'h0);
    cmp("async reset busy", {32'd0, busy}, 64'd0);
    cmp("async reset count", {48'd0, writeCount}, 64'd0);
    check_state("async reset");
    tick();
    check_state("reset held over write");
    $display("reset mid-write busy=%h count=%0d", busy, writeCount);
    reset_n = 1'b1;
    drive(1'b1, 5'd4, 64'h4444, 1'b0, 5'd0);
    tick();
    cmp("first write after reset", dataFromReg[4], 64'h4444);
    cmp("first write count", {48'd0, writeCount}, 64'd1);
    check_state("post reset");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
      tick();
      check_state($sformatf("rand%0d", n));
      $display("rand %0d we=%0d wr=%0d sb=%0d br=%0d busy=%h count=%0d",
               n, RegWrite, writeRegister, setBusy, busyRegister, busy, writeCount);
    end

    // Run the counter up to 0xFFFF, then wrap it.
    while (m_count != 65535) begin
      drive(1'b1, 5'($urandom_range(0, 30)), {$urandom, $urandom}, 1'b0, 5'd0);
      tick();
    end
    cmp("count at max", {48'd0, writeCount}, 64'h0000_0000_0000_FFFF);
    check_state("count at max");
    drive(1'b1, 5'd31, 64'h1, 1'b0, 5'd0);
    tick();
    cmp("xzr no wrap", {48'd0, writeCount}, 64'h0000_0000_0000_FFFF);
    drive(1'b1, 5'd12, 64'hC0FFEE, 1'b0, 5'd0);
    tick();
    cmp("count wrap", {48'd0, writeCount}, 64'h0);
    cmp("wrap write data", dataFromReg[12], 64'hC0FFEE);
    check_state("wrap");
    $display("wrap write count=%0d", writeCount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
